// File: rtl/mem_burst_initiator.sv
// Burst initiator for a synchronous byte RAM: streams write bytes into, or read bytes out of, consecutive wrapping addresses.
// Optional fill mode (constant-byte write bursts) is compiled in with `define MBI_FILL_EN.
module mem_burst_initiator #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic              cmd_fill,
    input  logic [DATA_W-1:0] cmd_fill_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid never depends on ready, and ready is a pure function of registered state.

    typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] count;
    logic              rd_p0;
    logic              rd_p1;
    logic [DATA_W-1:0] fifo_mem [4];
    logic [1:0]        wptr, rptr;
    logic [2:0]        fifo_cnt;
    logic [2:0]        credit_used;
    logic              fill_mode;
    logic [DATA_W-1:0] fill_byte;
    logic [DATA_W-1:0] beat_data;
    logic              cmd_fire, wr_beat, rd_issue, push, pop, last;

`ifdef MBI_FILL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_mode <= 1'b0;
            fill_byte <= '0;
        end else if (cmd_fire) begin
            fill_mode <= cmd_write & cmd_fill;
            fill_byte <= cmd_fill_data;
        end
    end
`else
    logic unused_fill;
    assign fill_mode   = 1'b0;
    assign fill_byte   = '0;
    assign unused_fill = ^{cmd_fill, cmd_fill_data};
`endif

    assign cmd_ready   = (state == IDLE);
    assign cmd_fire    = cmd_valid & cmd_ready;
    assign wr_ready    = (state == WRITE) & ~fill_mode;
    assign wr_beat     = (state == WRITE) & (fill_mode | wr_valid);
    assign beat_data   = fill_mode ? fill_byte : wr_data;
    assign last        = (count == '0);

    // Reads in flight (address registered, data returning) reserve FIFO space so it never overflows.
    assign credit_used = fifo_cnt + {2'b00, rd_p0} + {2'b00, rd_p1};
    assign rd_issue    = (state == READ) & (credit_used < 3'd4);
    assign push        = rd_p1;
    assign pop         = (fifo_cnt != 3'd0) & rd_ready;

    assign rd_valid    = (fifo_cnt != 3'd0);
    assign rd_data     = fifo_mem[rptr];
    assign busy        = (state != IDLE) | (fifo_cnt != 3'd0) | rd_p0 | rd_p1 | mem_wr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (cmd_fire) state_nxt = cmd_write ? WRITE : READ;
            WRITE: if (wr_beat && last) state_nxt = IDLE;
            READ:  if (rd_issue && last) state_nxt = DRAIN;
            DRAIN: if (!rd_p0 && !rd_p1 && fifo_cnt == 3'd0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_addr  <= '0;
            count     <= '0;
            mem_addr  <= '0;
            mem_wr    <= 1'b0;
            mem_wdata <= '0;
            rd_p0     <= 1'b0;
            rd_p1     <= 1'b0;
        end else begin
            mem_wr <= 1'b0;
            rd_p0  <= rd_issue;
            rd_p1  <= rd_p0;
            if (cmd_fire) begin
                cur_addr <= cmd_addr;
                count    <= cmd_len;
            end
            if (wr_beat) begin
                mem_addr  <= cur_addr;
                mem_wr    <= 1'b1;
                mem_wdata <= beat_data;
                cur_addr  <= cur_addr + ADDR_W'(1);
                count     <= count - ADDR_W'(1);
            end
            if (rd_issue) begin
                mem_addr <= cur_addr;
                cur_addr <= cur_addr + ADDR_W'(1);
                count    <= count - ADDR_W'(1);
            end
        end
    end

    // Storage is cleared on reset so rd_data reads zero while the FIFO is empty after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) fifo_mem[i] <= '0;
            wptr     <= 2'd0;
            rptr     <= 2'd0;
            fifo_cnt <= 3'd0;
        end else begin
            if (push) begin
                fifo_mem[wptr] <= mem_rdata;
                wptr           <= wptr + 2'd1;
            end
            if (pop) rptr <= rptr + 2'd1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_burst_initiator.sv
// Directed bench for mem_burst_initiator with a behavioural byte RAM and a shadow memory model.
// Covers the fill build (MBI_FILL_EN) and the default build.
`timescale 1ns/1ps
module tb_mem_burst_initiator;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0, cmd_write = 1'b0, cmd_fill = 1'b0;
    logic [6:0] cmd_addr = '0, cmd_len = '0;
    logic [7:0] cmd_fill_data = '0;
    logic       cmd_ready;
    logic       wr_valid = 1'b0, wr_ready;
    logic [7:0] wr_data = '0;
    logic       rd_valid, rd_ready = 1'b0;
    logic [7:0] rd_data;
    logic [6:0] mem_addr;
    logic       mem_wr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata = '0;
    logic       busy;

    logic [7:0] ram [128];
    logic [7:0] model [128];
    logic [7:0] exp_q [$];
    logic [7:0] wl_addr [$];
    logic [7:0] wl_data [$];
    int         wl_cyc [$];
    logic [7:0] al_q [$];
    int         total = 0, bad = 0, cyc = 0;

    mem_burst_initiator #(.ADDR_W(7), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_fill(cmd_fill), .cmd_fill_data(cmd_fill_data),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous RAM: write on strobe, read data registered one cycle after the address.
    always @(posedge clk) begin
        if (mem_wr) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    always @(negedge clk) begin
        if (mem_wr === 1'b1) begin
            wl_addr.push_back({1'b0, mem_addr});
            wl_data.push_back(mem_wdata);
            wl_cyc.push_back(cyc);
        end
        if (dut.rd_p0 === 1'b1) al_q.push_back({1'b0, mem_addr});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        wl_addr.delete(); wl_data.delete(); wl_cyc.delete(); al_q.delete();
    endtask

    task automatic send_cmd(input logic wr, input logic [6:0] a, input logic [6:0] l,
                            input logic f, input logic [7:0] fd);
        int n = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = l;
        cmd_fill = f; cmd_fill_data = fd;
        while (!cmd_ready && n < 300) begin @(negedge clk); n++; end
        if (n >= 300) check("cmd_accept_timeout", n, 0);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        @(negedge clk);
        while (busy && n < 300) begin @(negedge clk); n++; end
        if (n >= 300) check(tag, busy, 0);
    endtask

    task automatic stream_beats(input logic [6:0] a, input logic [6:0] l, input bit gap,
                                input logic [7:0] base);
        logic [6:0] ad;
        for (int i = 0; i <= int'(l); i++) begin
            int n = 0;
            @(negedge clk);
            wr_valid = 1'b1;
            wr_data  = base + 8'(i);
            while (!wr_ready && n < 50) begin @(negedge clk); n++; end
            if (n >= 50) begin check("wr_ready_timeout", n, 0); break; end
            if (i < int'(l)) check("cmd_ready_mid_write", cmd_ready, 0);
            ad = a + 7'(i);
            model[ad] = base + 8'(i);
            @(posedge clk);
            if (gap) begin @(negedge clk); wr_valid = 1'b0; end
        end
        @(negedge clk);
        wr_valid = 1'b0;
        wait_idle("write_idle_timeout");
    endtask

    task automatic check_wlog(input logic [6:0] a, input logic [6:0] l, input bit fill,
                              input logic [7:0] d, input bit consec);
        logic [6:0] ad;
        check("wlog_count", wl_addr.size(), int'(l) + 1);
        if (wl_addr.size() == int'(l) + 1) begin
            for (int i = 0; i <= int'(l); i++) begin
                ad = a + 7'(i);
                check("wlog_addr", wl_addr[i], {1'b0, ad});
                check("wlog_data", wl_data[i], fill ? d : d + 8'(i));
                if (consec && i > 0) check("wlog_consecutive", wl_cyc[i] - wl_cyc[i-1], 1);
            end
        end
    endtask

    task automatic read_burst(input logic [6:0] a, input logic [6:0] l, input bit rnd,
                              input int stop);
        int got = 0, n = 0, lat = -1, a0 = 0, maxocc = 0;
        bit busy_low = 0;
        logic [6:0] ad;
        exp_q.delete();
        for (int i = 0; i <= int'(l); i++) begin
            ad = a + 7'(i);
            exp_q.push_back(model[ad]);
        end
        send_cmd(1'b0, a, l, 1'b0, 8'h00);
        @(negedge clk);
        a0 = cyc;
        while (got < stop && n < 3000) begin
            rd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (int'(dut.fifo_cnt) > maxocc) maxocc = int'(dut.fifo_cnt);
            if (rd_valid && lat < 0) lat = cyc - a0;
            if (!busy) busy_low = 1;
            if (rd_valid && rd_ready) begin
                check("rd_data", rd_data, exp_q.pop_front());
                got++;
            end
            @(negedge clk);
            n++;
        end
        check("rd_first_latency", lat, 3);
        check("rd_count", got, stop);
        check("fifo_max_le4", maxocc <= 4, 1);
        check("busy_before_last_pop", busy_low, 0);
        if (stop == int'(l) + 1) begin
            rd_ready = 1'b0;
            wait_idle("read_idle_timeout");
            check("rd_valid_after_burst", rd_valid, 0);
            check("exp_q_drained", exp_q.size(), 0);
        end
    endtask

    initial begin
        // Reset values while rst_n is low.
        #2;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_wr_ready", wr_ready, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wr", mem_wr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_busy", busy, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Write burst 0x10 len 3 with wr_valid held high, then read it back.
        clear_logs();
        send_cmd(1'b1, 7'h10, 7'd3, 1'b0, 8'h00);
        stream_beats(7'h10, 7'd3, 1'b0, 8'hA0);
        check_wlog(7'h10, 7'd3, 1'b0, 8'hA0, 1'b1);
        read_burst(7'h10, 7'd3, 1'b0, 4);

        // Wrapping read across the top of the address space.
        send_cmd(1'b1, 7'h7E, 7'd3, 1'b0, 8'h00);
        stream_beats(7'h7E, 7'd3, 1'b0, 8'h11);
        clear_logs();
        read_burst(7'h7E, 7'd3, 1'b0, 4);
        check("wrap_issue_count", al_q.size(), 4);
        if (al_q.size() == 4) begin
            check("wrap_issue0", al_q[0], 8'h7E);
            check("wrap_issue1", al_q[1], 8'h7F);
            check("wrap_issue2", al_q[2], 8'h00);
            check("wrap_issue3", al_q[3], 8'h01);
        end

        // Full 128-byte preload, then a full read with random backpressure.
        send_cmd(1'b1, 7'h00, 7'd127, 1'b0, 8'h00);
        stream_beats(7'h00, 7'd127, 1'b0, 8'h35);
        read_burst(7'h00, 7'd127, 1'b1, 128);

        // Write with a gap every other cycle: only accepted beats reach the RAM.
        clear_logs();
        send_cmd(1'b1, 7'h40, 7'd5, 1'b0, 8'h00);
        stream_beats(7'h40, 7'd5, 1'b1, 8'h30);
        check_wlog(7'h40, 7'd5, 1'b0, 8'h30, 1'b0);
        read_burst(7'h40, 7'd5, 1'b0, 6);

        // Reset in the middle of a 20-byte read.
        read_burst(7'h00, 7'd19, 1'b0, 5);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_rd_valid", rd_valid, 0);
        check("midrst_mem_wr", mem_wr, 0);
        check("midrst_busy", busy, 0);
        check("midrst_rd_data", rd_data, 0);
        check("midrst_cmd_ready", cmd_ready, 1);
        exp_q.delete();
        rd_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("post_rst_no_data", rd_valid, 0);
        end
        read_burst(7'h00, 7'd0, 1'b0, 1);

        // Fill command.
        clear_logs();
`ifdef MBI_FILL_EN
        begin
            bit wr_seen = 0;
            int n = 0;
            send_cmd(1'b1, 7'h20, 7'd15, 1'b1, 8'h5A);
            @(negedge clk);
            while (busy && n < 100) begin
                if (wr_ready) wr_seen = 1;
                @(negedge clk);
                n++;
            end
            check("fill_idle", busy, 0);
            check("fill_wr_ready_low", wr_seen, 0);
            for (int i = 0; i < 16; i++) model[7'h20 + 7'(i)] = 8'h5A;
            check_wlog(7'h20, 7'd15, 1'b1, 8'h5A, 1'b1);
        end
`else
        send_cmd(1'b1, 7'h20, 7'd15, 1'b1, 8'h5A);
        repeat (4) @(negedge clk);
        check("nofill_no_writes", wl_addr.size(), 0);
        check("nofill_busy", busy, 1);
        check("nofill_wr_ready", wr_ready, 1);
        stream_beats(7'h20, 7'd15, 1'b0, 8'hC0);
        check_wlog(7'h20, 7'd15, 1'b0, 8'hC0, 1'b1);
`endif
        read_burst(7'h20, 7'd15, 1'b0, 16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
